// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings and fetch constants.
package instruction_fetch_controller_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
    localparam int unsigned PC_INCREMENT    = 4;

endpackage

// File: rtl/instruction_fetch_controller.sv
// Owns the PC, drives the combinational instruction memory and registers each fetched
// instruction into a one-entry valid/ready output stage for decode.
module instruction_fetch_controller
    import instruction_fetch_controller_pkg::*;
#(
    parameter int unsigned          WORDSIZE         = 64,
    parameter int unsigned          INSTRUCTION_SIZE = 32,
    parameter int unsigned          MEMORY_SIZE      = 1024,
    parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_halt_req,
    input  logic                        i_redirect_valid,
    input  logic [WORDSIZE-1:0]         i_redirect_pc,
    output logic [WORDSIZE-1:0]         o_imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] i_imem_instruction,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [INSTRUCTION_SIZE-1:0] o_out_instruction,
    output logic [WORDSIZE-1:0]         o_out_pc,
    output logic                        o_busy,
    output logic                        o_fault,
    output logic [WORDSIZE-1:0]         o_fault_pc
);

    localparam logic [WORDSIZE-3:0] MEM_WORDS = (WORDSIZE-2)'(MEMORY_SIZE);
    localparam logic [WORDSIZE-1:0] PC_STEP   = WORDSIZE'(PC_INCREMENT);

    fetch_state_e                r_state;
    logic [WORDSIZE-1:0]         r_pc;
    logic                        r_out_valid;
    logic [INSTRUCTION_SIZE-1:0] r_out_instruction;
    logic [WORDSIZE-1:0]         r_out_pc;
    logic                        r_fault;
    logic [WORDSIZE-1:0]         r_fault_pc;

    fetch_state_e                w_state_next;
    logic [WORDSIZE-1:0]         w_pc_next;
    logic                        w_out_valid_next;
    logic [INSTRUCTION_SIZE-1:0] w_out_instruction_next;
    logic [WORDSIZE-1:0]         w_out_pc_next;
    logic                        w_fault_next;
    logic [WORDSIZE-1:0]         w_fault_pc_next;

    logic w_transfer;
    logic w_slot_free;
    logic w_misaligned;
    logic w_out_of_range;

    assign w_transfer     = r_out_valid && i_out_ready;
    assign w_slot_free    = !r_out_valid || i_out_ready;
    assign w_misaligned   = |i_redirect_pc[1:0];
    assign w_out_of_range = r_pc[WORDSIZE-1:2] >= MEM_WORDS;

    always_comb begin
        w_state_next           = r_state;
        w_pc_next              = r_pc;
        w_out_valid_next       = r_out_valid && !w_transfer;
        w_out_instruction_next = r_out_instruction;
        w_out_pc_next          = r_out_pc;
        w_fault_next           = r_fault;
        w_fault_pc_next        = r_fault_pc;

        case (r_state)
            FETCH_IDLE: begin
                if (i_start) begin
                    w_state_next = FETCH_RUN;
                end
                // A misaligned entry point faults even if start arrives alongside it.
                if (i_redirect_valid) begin
                    w_pc_next = i_redirect_pc;
                    if (w_misaligned) begin
                        w_state_next    = FETCH_FAULT;
                        w_fault_next    = 1'b1;
                        w_fault_pc_next = i_redirect_pc;
                    end
                end
            end
            FETCH_RUN: begin
                if (i_redirect_valid) begin
                    w_out_valid_next = 1'b0;
                    w_pc_next        = i_redirect_pc;
                    if (w_misaligned) begin
                        w_state_next    = FETCH_FAULT;
                        w_fault_next    = 1'b1;
                        w_fault_pc_next = i_redirect_pc;
                    end
                end else if (i_halt_req) begin
                    w_state_next = FETCH_IDLE;
                end else if (w_out_of_range) begin
                    w_state_next    = FETCH_FAULT;
                    w_fault_next    = 1'b1;
                    w_fault_pc_next = r_pc;
                end else if (w_slot_free) begin
                    w_out_valid_next       = 1'b1;
                    w_out_instruction_next = i_imem_instruction;
                    w_out_pc_next          = r_pc;
                    w_pc_next              = r_pc + PC_STEP;
                end
            end
            FETCH_FAULT: begin
            end
            default: begin
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state           <= FETCH_IDLE;
            r_pc              <= RESET_PC;
            r_out_valid       <= 1'b0;
            r_out_instruction <= '0;
            r_out_pc          <= '0;
            r_fault           <= 1'b0;
            r_fault_pc        <= '0;
        end else begin
            r_state           <= w_state_next;
            r_pc              <= w_pc_next;
            r_out_valid       <= w_out_valid_next;
            r_out_instruction <= w_out_instruction_next;
            r_out_pc          <= w_out_pc_next;
            r_fault           <= w_fault_next;
            r_fault_pc        <= w_fault_pc_next;
        end
    end

    assign o_imem_addr       = {2'b00, r_pc[WORDSIZE-1:2]};
    assign o_out_valid       = r_out_valid;
    assign o_out_instruction = r_out_instruction;
    assign o_out_pc          = r_out_pc;
    assign o_busy            = (r_state == FETCH_RUN);
    assign o_fault           = r_fault;
    assign o_fault_pc        = r_fault_pc;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench: directed scenarios plus a randomized backpressure/redirect stream
// checked against an in-order expected-PC scoreboard.
module tb_instruction_fetch_controller;

    localparam int unsigned WS = 64;
    localparam int unsigned IS = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          halt_req;
    logic          redirect_valid;
    logic [WS-1:0] redirect_pc;
    logic [WS-1:0] imem_addr;
    logic [IS-1:0] imem_instruction;
    logic          out_valid;
    logic          out_ready;
    logic [IS-1:0] out_instruction;
    logic [WS-1:0] out_pc;
    logic          busy;
    logic          fault;
    logic [WS-1:0] fault_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory model: word i holds A000_0000 + i.
    assign imem_instruction = 32'hA000_0000 + imem_addr[31:0];

    function automatic logic [IS-1:0] mem_at(input logic [WS-1:0] pc);
        return 32'hA000_0000 + pc[33:2];
    endfunction

    instruction_fetch_controller dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_halt_req         (halt_req),
        .i_redirect_valid   (redirect_valid),
        .i_redirect_pc      (redirect_pc),
        .o_imem_addr        (imem_addr),
        .i_imem_instruction (imem_instruction),
        .o_out_valid        (out_valid),
        .i_out_ready        (out_ready),
        .o_out_instruction  (out_instruction),
        .o_out_pc           (out_pc),
        .o_busy             (busy),
        .o_fault            (fault),
        .o_fault_pc         (fault_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_pc !== '0 || out_instruction !== '0) begin n_err++; $display("FAIL reset_out: got pc %h ins %h want 0 0", out_pc, out_instruction); end
        n_cmp++; if (busy !== 1'b0 || fault !== 1'b0 || fault_pc !== '0) begin n_err++; $display("FAIL reset_status: got busy %b fault %b fpc %h want 0 0 0", busy, fault, fault_pc); end
        n_cmp++; if (imem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_basic();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency: got busy %b valid %b want 1 0", busy, out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== WS'(4 * i) || out_instruction !== mem_at(WS'(4 * i))) begin
                n_err++;
                $display("FAIL basic_stream%0d: got v %b pc %h ins %h want 1 %h %h", i, out_valid, out_pc, out_instruction, 4 * i, mem_at(WS'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 64'h8 || out_instruction !== 32'hA000_0002 || imem_addr !== 64'd3) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v %b pc %h ins %h addr %h want 1 8 A0000002 3", i, out_valid, out_pc, out_instruction, imem_addr);
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'hC) begin n_err++; $display("FAIL bp_release: got v %b pc %h want 1 c", out_valid, out_pc); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instruction !== 32'hA000_0010) begin
            n_err++;
            $display("FAIL redir_target: got v %b pc %h ins %h want 1 40 A0000010", out_valid, out_pc, out_instruction);
        end
    endtask

    // Expected transfer order: consecutive PCs from the last redirect target.
    task automatic test_random_stream();
        logic [WS-1:0] exp_pc;
        logic [WS-1:0] snap_pc;
        logic [IS-1:0] snap_ins;
        logic          snap_v;
        logic          rdy;
        logic          redir;
        int            n_xfer;
        exp_pc = 64'h40;
        n_xfer = 0;
        for (int i = 0; i < 200; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            out_ready      = rdy;
            redirect_valid = redir;
            redirect_pc    = WS'($urandom_range(0, 700) * 4);
            snap_v = out_valid; snap_pc = out_pc; snap_ins = out_instruction;
            if (snap_v && rdy) begin
                n_xfer++;
                n_cmp++;
                if (snap_pc !== exp_pc || snap_ins !== mem_at(exp_pc)) begin
                    n_err++;
                    $display("FAIL rand_xfer%0d: got pc %h ins %h want %h %h", i, snap_pc, snap_ins, exp_pc, mem_at(exp_pc));
                end
                exp_pc = exp_pc + 4;
            end
            tick();
            if (redir) begin
                exp_pc = redirect_pc;
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_flush%0d: got %b want 0", i, out_valid); end
            end else if (snap_v && !rdy) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== snap_pc || out_instruction !== snap_ins) begin
                    n_err++;
                    $display("FAIL rand_stall%0d: got v %b pc %h ins %h want 1 %h %h", i, out_valid, out_pc, out_instruction, snap_pc, snap_ins);
                end
            end
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (busy !== 1'b1 || n_xfer == 0) begin n_err++; $display("FAIL rand_progress: got busy %b xfers %0d want 1 >0", busy, n_xfer); end
    endtask

    task automatic test_halt();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        out_ready = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h4) begin
            n_err++;
            $display("FAIL halt_hold: got busy %b v %b pc %h want 0 1 4", busy, out_valid, out_pc);
        end
        tick(); tick();
        n_cmp++; if (out_pc !== 64'h4 || imem_addr !== 64'd2) begin n_err++; $display("FAIL halt_nofetch: got pc %h addr %h want 4 2", out_pc, imem_addr); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_drain: got %b want 0", out_valid); end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h8) begin n_err++; $display("FAIL halt_resume: got v %b pc %h want 1 8", out_valid, out_pc); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 64'h42;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if (fault !== 1'b1 || fault_pc !== 64'h42 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL misal_fault: got f %b fpc %h busy %b v %b want 1 42 0 0", fault, fault_pc, busy, out_valid);
        end
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h80;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || fault_pc !== 64'h42 || imem_addr !== 64'h10) begin
                n_err++;
                $display("FAIL misal_ignore%0d: got v %b busy %b fpc %h addr %h want 0 0 42 10", i, out_valid, busy, fault_pc, imem_addr);
            end
        end
        start = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_range();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 64'hFFC;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (imem_addr !== 64'd1023 || busy !== 1'b0) begin n_err++; $display("FAIL range_entry: got addr %h busy %b want 3ff 0", imem_addr, busy); end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 64'hFFC || out_instruction !== 32'hA000_03FF) begin
            n_err++;
            $display("FAIL range_last: got v %b pc %h ins %h want 1 ffc A00003FF", out_valid, out_pc, out_instruction);
        end
        tick();
        n_cmp++;
        if (fault !== 1'b1 || fault_pc !== 64'h1000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL range_fault: got f %b fpc %h v %b busy %b want 1 1000 0 0", fault, fault_pc, out_valid, busy);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || fault !== 1'b1) begin n_err++; $display("FAIL range_sticky: got v %b f %b want 0 1", out_valid, fault); end
    endtask

    task automatic test_reset_midrun();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_cmp++; if (fault !== 1'b0 || fault_pc !== '0 || imem_addr !== '0) begin n_err++; $display("FAIL rst_fault: got f %b fpc %h addr %h want 0 0 0", fault, fault_pc, imem_addr); end
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_instruction !== '0 || busy !== 1'b0 || imem_addr !== '0) begin
            n_err++;
            $display("FAIL rst_midrun: got v %b pc %h ins %h busy %b addr %h want all 0", out_valid, out_pc, out_instruction, busy, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_random_stream();
        test_halt();
        test_misaligned();
        test_range();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
